// File: rtl/mtm_alu_serializer.sv
// mtm_alu_serializer
// Output serializer for the mtm ALU. A result word and its control byte are
// captured from the core and sent on a single wire as 11-bit frames
// (start=0, type, 8 payload bits MSB first, stop=1). A normal result is sent
// as four DATA frames (C, MSB byte first) followed by one CTL frame. An
// error/status code (ctl_in[7]=1) is sent as a single CTL frame.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   valid    one-cycle strobe, c_in/ctl_in carry a new result
//   c_in     32-bit result word
//   ctl_in   control byte (8'hFF = core idle code, never transmitted)
//   sout     registered serial output, idles high
//   busy     high while a transmission is on the line
//   overrun  sticky flag, valid seen while busy (cleared only by reset)
//
// State | meaning
// IDLE  | waiting for a result
// START | start bit (0)
// TYPE  | type bit (0=DATA, 1=CTL)
// DATA  | 8 payload bits, MSB first
// STOP  | stop bit (1), then next frame or IDLE

module mtm_alu_serializer #(
  parameter int BIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [31:0] c_in,
  input  logic [7:0]  ctl_in,
  output logic        sout,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, START, TYPE, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  baud_cnt, baud_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic [2:0]  frame_idx, frame_nxt;
  logic [31:0] c_reg;
  logic [7:0]  ctl_reg;
  logic        err_mode;
  logic [7:0]  payload;
  logic        active, accept, tc, ctl_frame, sout_nxt;

  // The state register runs one cycle ahead of sout/busy, so the line is
  // still considered occupied in the capture cycle before busy rises.
  assign active    = busy | (state != IDLE);
  assign accept    = valid & ~active & (ctl_in != 8'hFF);
  assign tc        = (baud_cnt == 8'(BIT_CYCLES - 1));
  assign ctl_frame = err_mode | (frame_idx == 3'd4);

  always_comb begin
    payload = ctl_reg;
    if (!ctl_frame) begin
      case (frame_idx)
        3'd0:    payload = c_reg[31:24];
        3'd1:    payload = c_reg[23:16];
        3'd2:    payload = c_reg[15:8];
        default: payload = c_reg[7:0];
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    frame_nxt = frame_idx;
    sout_nxt  = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          baud_nxt  = '0;
          bit_nxt   = '0;
          frame_nxt = '0;
        end
      end
      default: begin
        if (tc) begin
          baud_nxt = '0;
          case (state)
            START: state_nxt = TYPE;
            TYPE: begin
              state_nxt = DATA;
              bit_nxt   = '0;
            end
            DATA: begin
              if (bit_idx == 3'd7) state_nxt = STOP;
              else bit_nxt = bit_idx + 3'd1;
            end
            default: begin
              if (ctl_frame) begin
                state_nxt = IDLE;
              end else begin
                state_nxt = START;
                frame_nxt = frame_idx + 3'd1;
              end
            end
          endcase
        end else begin
          baud_nxt = baud_cnt + 8'd1;
        end
      end
    endcase
    case (state)
      START:   sout_nxt = 1'b0;
      TYPE:    sout_nxt = ctl_frame;
      DATA:    sout_nxt = payload[3'd7 - bit_idx];
      default: sout_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      frame_idx <= '0;
      c_reg     <= '0;
      ctl_reg   <= '0;
      err_mode  <= 1'b0;
      sout      <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_idx   <= bit_nxt;
      frame_idx <= frame_nxt;
      if (accept) begin
        c_reg    <= c_in;
        ctl_reg  <= ctl_in;
        err_mode <= ctl_in[7];
      end
      sout <= sout_nxt;
      busy <= (state != IDLE);
      if (valid && active && (ctl_in != 8'hFF)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
module tb_mtm_alu_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0 = 1'b0, rst_n1 = 1'b0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic [31:0] c0 = '0, c1 = '0;
  logic [7:0]  ctl0 = '0, ctl1 = '0;
  logic        sout0, busy0, ovr0, sout1, busy1, ovr1;

  mtm_alu_serializer #(.BIT_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n0), .valid(valid0), .c_in(c0), .ctl_in(ctl0),
    .sout(sout0), .busy(busy0), .overrun(ovr0));

  mtm_alu_serializer #(.BIT_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n1), .valid(valid1), .c_in(c1), .ctl_in(ctl1),
    .sout(sout1), .busy(busy1), .overrun(ovr1));

  int n_vec = 0;
  int n_err = 0;

  // expected frames as 11-bit vectors, first bit on the line in bit 10
  logic [10:0] fq0[$], fq1[$];
  int          lq0[$], lq1[$];

  function automatic logic get_sout(input int inst);
    return (inst == 0) ? sout0 : sout1;
  endfunction
  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_ovr(input int inst);
    return (inst == 0) ? ovr0 : ovr1;
  endfunction
  function automatic logic get_rst(input int inst);
    return (inst == 0) ? rst_n0 : rst_n1;
  endfunction
  function automatic int bit_cycles(input int inst);
    return (inst == 0) ? 1 : 4;
  endfunction

  function automatic void drive(input int inst, input logic v,
                                input logic [31:0] c, input logic [7:0] ctl);
    if (inst == 0) begin valid0 = v; c0 = c; ctl0 = ctl; end
    else begin valid1 = v; c1 = c; ctl1 = ctl; end
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // reference model: a result becomes a list of frames and a busy length
  function automatic void model_push(input int inst, input logic [31:0] c, input logic [7:0] ctl);
    logic [10:0] f[$];
    int len;
    if (ctl == 8'hFF) return;
    if (ctl[7]) begin
      f.push_back({1'b0, 1'b1, ctl, 1'b1});
      len = 11 * bit_cycles(inst);
    end else begin
      for (int b = 0; b < 4; b++) f.push_back({1'b0, 1'b0, c[31 - 8*b -: 8], 1'b1});
      f.push_back({1'b0, 1'b1, ctl, 1'b1});
      len = 55 * bit_cycles(inst);
    end
    foreach (f[i]) begin
      if (inst == 0) fq0.push_back(f[i]); else fq1.push_back(f[i]);
    end
    if (inst == 0) lq0.push_back(len); else lq1.push_back(len);
  endfunction

  function automatic void flush(input int inst);
    if (inst == 0) begin fq0.delete(); lq0.delete(); end
    else begin fq1.delete(); lq1.delete(); end
  endfunction

  // called at a negedge: present one valid cycle, record the expected response
  task automatic send(input int inst, input logic [31:0] c, input logic [7:0] ctl);
    drive(inst, 1'b1, c, ctl);
    model_push(inst, c, ctl);
    @(negedge clk);
    drive(inst, 1'b0, c, ctl);
  endtask

  task automatic wait_idle(input int inst);
    int t = 0;
    @(negedge clk);
    while (get_busy(inst) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle%0d: busy still 1 after %0d cycles, expected 0", inst, t);
    end
  endtask

  task automatic frame_mon(input int inst);
    int bc;
    logic [10:0] got, exp;
    logic bad, aborted, b;
    bc = bit_cycles(inst);
    forever begin
      @(negedge clk);
      if (get_rst(inst) && !get_sout(inst)) begin
        got = '0; bad = 1'b0; aborted = 1'b0; b = 1'b0;
        for (int i = 0; i < 11 && !aborted; i++) begin
          for (int k = 0; k < bc && !aborted; k++) begin
            if (i > 0 || k > 0) @(negedge clk);
            if (!get_rst(inst)) aborted = 1'b1;
            else if (k == 0) b = get_sout(inst);
            else if (get_sout(inst) != b) bad = 1'b1;
          end
          got = {got[9:0], b};
        end
        if (!aborted) begin
          n_vec++;
          if ((inst == 0 && fq0.size() == 0) || (inst == 1 && fq1.size() == 0)) begin
            n_err++;
            $display("FAIL frame%0d: got unexpected frame %b, expected none", inst, got);
          end else begin
            exp = (inst == 0) ? fq0.pop_front() : fq1.pop_front();
            if (bad || got != exp) begin
              n_err++;
              $display("FAIL frame%0d: got %b (hold_err=%0d) expected %b", inst, got, bad, exp);
            end
          end
        end
      end
    end
  endtask

  task automatic busy_mon(input int inst);
    int run = 0;
    int exp;
    forever begin
      @(negedge clk);
      if (!get_rst(inst)) run = 0;
      else if (get_busy(inst)) run++;
      else if (run > 0) begin
        n_vec++;
        if ((inst == 0 && lq0.size() == 0) || (inst == 1 && lq1.size() == 0)) begin
          n_err++;
          $display("FAIL busy_len%0d: got %0d cycles, expected no transmission", inst, run);
        end else begin
          exp = (inst == 0) ? lq0.pop_front() : lq1.pop_front();
          if (run != exp) begin
            n_err++;
            $display("FAIL busy_len%0d: got %0d expected %0d", inst, run, exp);
          end
        end
        run = 0;
      end
    end
  endtask

  initial begin
    fork
      frame_mon(0);
      frame_mon(1);
      busy_mon(0);
      busy_mon(1);
    join_none
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [31:0] rc;
    logic [7:0] rctl;

    // reset and idle
    #12;
    check("rst_sout", {31'd0, sout0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_ovr",  {31'd0, ovr0},  32'd0);
    @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!sout0 || busy0) seen = 1'b1;
    end
    check("idle_line", {31'd0, seen}, 32'd0);

    // normal result, plus start-bit latency
    send(0, 32'h12345678, 8'h0B);
    check("lat_busy_n0", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    check("lat_busy_n1", {31'd0, busy0}, 32'd1);
    check("lat_sout_n1", {31'd0, sout0}, 32'd0);
    wait_idle(0);

    // error code
    send(0, 32'hDEADBEEF, 8'h93);
    wait_idle(0);

    // overrun 10 cycles into a normal transmission
    send(0, 32'h12345678, 8'h0B);
    repeat (9) @(negedge clk);
    check("ovr_before", {31'd0, ovr0}, 32'd0);
    drive(0, 1'b1, 32'hFFFFFFFF, 8'h00);
    @(negedge clk);
    drive(0, 1'b0, 32'hA5A5A5A5, 8'h3C);
    check("ovr_set", {31'd0, ovr0}, 32'd1);
    wait_idle(0);
    check("ovr_sticky", {31'd0, ovr0}, 32'd1);
    send(0, 32'hCAFEF00D, 8'h21);
    wait_idle(0);

    // valid in the cycle busy falls is refused; the next cycle is accepted
    send(0, 32'h0F1E2D3C, 8'h05);
    repeat (55) @(negedge clk);
    check("last_busy", {31'd0, busy0}, 32'd1);
    drive(0, 1'b1, 32'h11111111, 8'h22);
    @(negedge clk);
    drive(0, 1'b0, 32'h11111111, 8'h22);
    check("fall_busy", {31'd0, busy0}, 32'd0);
    send(0, 32'h89ABCDEF, 8'h7E);
    wait_idle(0);
    check("ovr_still", {31'd0, ovr0}, 32'd1);

    // BIT_CYCLES=4
    @(negedge clk);
    send(1, 32'h00000001, 8'h40);
    wait_idle(1);

    // mid-frame reset
    @(negedge clk);
    send(0, 32'h12345678, 8'h0B);
    repeat (29) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n0 = 1'b0;
    flush(0);
    #1;
    check("midrst_sout", {31'd0, sout0}, 32'd1);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_ovr",  {31'd0, ovr0},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n0 = 1'b1;
    @(negedge clk);

    // idle code filter
    send(0, 32'h12345678, 8'hFF);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy0 || !sout0) seen = 1'b1;
    end
    check("ff_no_frame", {31'd0, seen}, 32'd0);
    check("ff_no_ovr", {31'd0, ovr0}, 32'd0);

    // randomized results
    for (int n = 0; n < 40; n++) begin
      int inst;
      inst = (n % 8 == 7) ? 1 : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rc = $urandom;
      rctl = (n % 9 == 4) ? 8'hFF : 8'($urandom_range(0, 255));
      send(inst, rc, rctl);
      if (rctl != 8'hFF) begin
        repeat ($urandom_range(2, 8)) @(negedge clk);
        drive(inst, 1'b0, $urandom, 8'($urandom_range(0, 255)));
      end
      wait_idle(inst);
    end

    repeat (5) @(negedge clk);
    check("pending_frames0", fq0.size(), 0);
    check("pending_frames1", fq1.size(), 0);
    check("pending_busy",    lq0.size() + lq1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mtm_alu_serializer.md
Name: mtm_alu_serializer

Overview:
Output serializer for the mtm ALU. It captures a result word C and its control byte from the ALU core and transmits them on a single-wire serial line as 11-bit frames.
- Normal result: 4 DATA frames (C, MSB byte first) followed by 1 CTL frame.
- Error/status code: the CTL frame only.
It sits between the core outputs and the chip-level `sout` pin, and is the mirror of the input deserializer.

Parameters:
- BIT_CYCLES, 1: clock cycles each serial bit is held on `sout` (range 1..255).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid  in  1  one-cycle strobe; `c_in`/`ctl_in` hold a new result this cycle.
- c_in  in  32  result word from the core.
- ctl_in  in  8  control byte from the core.
- sout  out  1  serial output; idles high.
- busy  out  1  high while a transmission is in progress.
- overrun  out  1  sticky; set when `valid` arrives while busy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- Reset: asserting `rst_n` low immediately forces:
  - sout=1, busy=0, overrun=0;
  - FSM=IDLE; all counters and capture registers cleared.
  - Reset mid-frame aborts the frame with no completion; `sout` returns high at once.
- Frame format (11 bits, in order): start=0, type (0=DATA, 1=CTL), 8 payload bits MSB first, stop=1.
- Capture: on a rising edge with valid=1 and busy=0:
  - latch `c_in` and `ctl_in`;
  - mode = ERR if ctl_in[7]=1, else NORMAL.
- ctl_in=8'hFF with valid=1 is the core's idle/reset code: not transmitted, not an overrun.
- Overrun: valid=1 while busy=1 is ignored (no capture) and sets `overrun`. `overrun` clears only on reset.
- busy:
  - goes high on the edge after capture;
  - stays high through the final cycle of the last stop bit;
  - falls on the following edge.
- The first `sout` low (start bit) appears on that same edge as busy rising, i.e. 1-cycle latency from the valid edge.
- FSM states: IDLE -> START -> TYPE -> DATA(8 bits) -> STOP.
  - From STOP: go to START if frames remain, else IDLE.
  - There is no idle gap between consecutive frames.
- Baud counter: counts 0..BIT_CYCLES-1. The FSM advances only on terminal count. Each bit is held exactly BIT_CYCLES cycles.
- Frame counter (0..4):
  - NORMAL: frames 0-3 are DATA with payloads C[31:24], C[23:16], C[15:8], C[7:0]; frame 4 is CTL with payload `ctl_in`.
  - ERR: a single CTL frame.
- Totals: NORMAL = 55*BIT_CYCLES cycles of busy; ERR = 11*BIT_CYCLES.
- Type bit: 0 on DATA frames, 1 on CTL frames.
- Inputs are not re-sampled during transmission; changes on `c_in`/`ctl_in` while busy have no effect.
- valid asserted in the cycle busy falls is still refused (busy=1 at that edge) and flagged as overrun. Acceptance resumes the next cycle.
- `sout` is a registered output; it never glitches and is high in IDLE.

Test Plan:
- Reset then idle, BIT_CYCLES=1:
  - rst_n low -> sout=1, busy=0, overrun=0;
  - 20 idle cycles -> sout stays 1.
- Normal result, BIT_CYCLES=1: valid with c_in=32'h12345678, ctl_in=8'h0B ->
  - 55 bits: 0 0 00010010 1 | 0 0 00110100 1 | 0 0 01010110 1 | 0 0 01111000 1 | 0 1 00001011 1;
  - busy high exactly 55 cycles; start bit one cycle after the valid edge.
- Error code: valid with ctl_in=8'h93, c_in=32'hDEADBEEF ->
  - 11 bits: 0 1 10010011 1;
  - busy high 11 cycles; C never sent.
- Overrun: second valid (c_in=32'hFFFFFFFF, ctl_in=8'h00) 10 cycles into the NORMAL frame above ->
  - bitstream unchanged; overrun=1 and stays 1;
  - a new valid after busy falls transmits normally.
- BIT_CYCLES=4: valid with c_in=32'h00000001, ctl_in=8'h40 ->
  - each bit held 4 cycles; busy high 220 cycles;
  - last DATA payload 00000001, CTL payload 01000000.
- Mid-frame reset and 8'hFF filter:
  - rst_n low at cycle 30 of a NORMAL transmission -> sout=1, busy=0 immediately;
  - valid with ctl_in=8'hFF -> no frame, busy stays 0.
